hq_c1_ring_writer: RTL

Sits between the message FIFO inside hq_fifo_afu and the CCI-P C1 Tx channel. It drains 512-bit cache-line messages into a host-memory ring buffer at base + index. It issues one C1 write request per accepted line and wraps the index at the configured ring size. It tracks outstanding writes against C1 write responses and honours the C1 almost-full back-pressure.

---
 rtl/hq_c1_ring_writer_if.sv | 24 ++
 rtl/hq_c1_ring_writer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hq_c1_ring_writer_if.sv
// Message-in and CCI-P C1 Tx/Rx signals between the AFU message FIFO, the ring
// writer and the C1 channel. master = ring writer side, slave = FIFO/C1 side.
interface hq_c1_ring_writer_if;
    logic         in_valid;
    logic [511:0] in_data;
    logic         in_ready;
    logic         c1_tx_almfull;
    logic         c1_tx_valid;
    logic [41:0]  c1_tx_addr;
    logic [511:0] c1_tx_data;
    logic [15:0]  c1_tx_mdata;
    logic         c1_tx_fence;
    logic         c1_rx_wrrsp;

    modport master (
        input  in_valid, in_data, c1_tx_almfull, c1_rx_wrrsp,
        output in_ready, c1_tx_valid, c1_tx_addr, c1_tx_data, c1_tx_mdata, c1_tx_fence
    );

    modport slave (
        output in_valid, in_data, c1_tx_almfull, c1_rx_wrrsp,
        input  in_ready, c1_tx_valid, c1_tx_addr, c1_tx_data, c1_tx_mdata, c1_tx_fence
    );
endinterface

// File: rtl/hq_c1_ring_writer.sv
// Drains 512-bit message lines into a host ring buffer as CCI-P C1 writes.
// Optional HQ_RING_WRFENCE_EN: a WrFence is issued after every ring wrap.
module hq_c1_ring_writer #(
    parameter int MAX_OUTSTANDING = 64,
    parameter int INDEX_W         = 16,
    parameter int RING_LOG2_MAX   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_enable,
    input  logic [41:0]        cfg_base_addr,
    input  logic [4:0]         cfg_ring_log2,
    hq_c1_ring_writer_if.master bus,
    output logic [INDEX_W-1:0] wr_index,
    output logic [7:0]         outstanding,
    output logic               drained,
    output logic               rsp_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
`ifdef HQ_RING_WRFENCE_EN
        , FENCE = 2'd3
`endif
    } state_t;

    state_t             state, stateNext;
    logic [4:0]         ringLog2;
    logic [4:0]         log2Clamp;
    logic [INDEX_W-1:0] lastIdx;
    logic               isLast;
    logic [8:0]         credUsed;
    logic               credOk;
    logic               runReady;
    logic               accept;
    logic               fenceGo;
    logic [7:0]         outNext;

    assign log2Clamp = (cfg_ring_log2 > 5'(RING_LOG2_MAX)) ? 5'(RING_LOG2_MAX) : cfg_ring_log2;
    assign lastIdx   = ~({INDEX_W{1'b1}} << ringLog2);
    assign isLast    = (wr_index == lastIdx);

    // The request sitting in the output register is not yet in outstanding,
    // so it must hold a credit or a back-to-back stream would overshoot.
    assign credUsed  = {1'b0, outstanding} + {8'd0, bus.c1_tx_valid};
    assign credOk    = credUsed < 9'(MAX_OUTSTANDING);
    assign runReady  = (state == RUN) && !bus.c1_tx_almfull && credOk && cfg_enable;
    assign bus.in_ready = runReady;
    assign accept    = bus.in_valid && runReady;

    always_comb begin
        stateNext = state;
        fenceGo   = 1'b0;
        case (state)
            IDLE:  if (cfg_enable) stateNext = RUN;
            RUN: begin
`ifdef HQ_RING_WRFENCE_EN
                if (accept && isLast) stateNext = FENCE;
                else
`endif
                if (!cfg_enable) stateNext = DRAIN;
            end
            DRAIN: if (outstanding == 8'd0 && !bus.c1_tx_valid) stateNext = IDLE;
`ifdef HQ_RING_WRFENCE_EN
            FENCE: begin
                if (!bus.c1_tx_almfull && credOk) begin
                    fenceGo   = 1'b1;
                    stateNext = cfg_enable ? RUN : DRAIN;
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        outNext = outstanding;
        if (bus.c1_tx_valid && !bus.c1_rx_wrrsp)
            outNext = outstanding + 8'd1;
        else if (!bus.c1_tx_valid && bus.c1_rx_wrrsp && outstanding != 8'd0)
            outNext = outstanding - 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            ringLog2        <= 5'd0;
            wr_index        <= '0;
            outstanding     <= 8'd0;
            drained         <= 1'b0;
            rsp_err         <= 1'b0;
            bus.c1_tx_valid <= 1'b0;
            bus.c1_tx_addr  <= '0;
            bus.c1_tx_data  <= '0;
            bus.c1_tx_mdata <= '0;
`ifdef HQ_RING_WRFENCE_EN
            bus.c1_tx_fence <= 1'b0;
`endif
        end else begin
            state       <= stateNext;
            outstanding <= outNext;
            drained     <= (stateNext == IDLE) && (outNext == 8'd0);
            rsp_err     <= rsp_err | (bus.c1_rx_wrrsp && outstanding == 8'd0);

            if (state == IDLE && cfg_enable) begin
                ringLog2 <= log2Clamp;
                wr_index <= '0;
            end else if (accept) begin
                wr_index <= isLast ? '0 : wr_index + INDEX_W'(1);
            end

            bus.c1_tx_valid <= accept || fenceGo;
`ifdef HQ_RING_WRFENCE_EN
            bus.c1_tx_fence <= fenceGo;
`endif
            if (accept) begin
                bus.c1_tx_addr  <= cfg_base_addr + 42'(wr_index);
                bus.c1_tx_data  <= bus.in_data;
                bus.c1_tx_mdata <= 16'(wr_index);
            end else if (fenceGo) begin
                bus.c1_tx_addr  <= '0;
                bus.c1_tx_data  <= '0;
                bus.c1_tx_mdata <= 16'hFFFF;
            end
        end
    end

`ifndef HQ_RING_WRFENCE_EN
    assign bus.c1_tx_fence = 1'b0;
`endif
endmodule
